ym_cmd_sequencer: RTL and testbench

YM_CMD_SEQUENCER -- requirements
Module: ym_cmd_sequencer

---
 rtl/ym_cmd_sequencer.sv | 130 +++++++++++++
 tb/tb_ym_cmd_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ym_cmd_sequencer.sv
// Command FIFO plus write-strobe sequencer for a YM synth array.
// Each queued command becomes a timed cs/addr/din write, or a pure delay when cs is 0.
module ym_cmd_sequencer #(
    parameter int FIFO_DEPTH = 16,
    parameter int WR_PULSE   = 6,
    parameter int ADDR_GAP   = 12,
    parameter int DATA_GAP   = 192
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [14:0]                   cmd_data,
    output logic [4:0]                    cs,
    output logic [1:0]                    addr,
    output logic [7:0]                    din,
    output logic                          wr_n,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    // state  | meaning
    // IDLE   | waiting for a queued command, pops it when present
    // SETUP  | cs/addr/din settled, strobe not yet asserted
    // STROBE | wr_n low for WR_PULSE cycles
    // HOLD   | wr_n released, cs/addr/din still held
    // GAP    | cs dropped, chip recovery time after the write
    // WAIT   | cs=0 command, (din+1)*64 idle cycles
    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_GAP, ST_WAIT
    } state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = 15;
    localparam logic [CW-1:0] STROBE_LOAD = CW'(WR_PULSE - 1);
    localparam logic [CW-1:0] ADDR_LOAD   = CW'(ADDR_GAP - 1);
    localparam logic [CW-1:0] DATA_LOAD   = CW'(DATA_GAP - 1);

    state_t          state;
    logic [14:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;

    logic            push;
    logic            pop;
    logic            exit_now;
    logic [LW-1:0]   level_next;
    logic [14:0]     head;
    logic [CW-1:0]   wait_load;

    assign cmd_ready  = !rst && (fifo_level != LW'(FIFO_DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == ST_IDLE) && (fifo_level != '0);
    assign exit_now   = ((state == ST_GAP) || (state == ST_WAIT)) && (cnt == '0);
    assign level_next = fifo_level + {{(LW-1){1'b0}}, push} - {{(LW-1){1'b0}}, pop};
    assign head       = mem[rd_ptr];
    // (din+1)*64-1 is just din with six ones appended
    assign wait_load  = {1'b0, head[7:0], 6'h3F};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cs         <= '0;
            addr       <= '0;
            din        <= '0;
            wr_n       <= 1'b1;
            busy       <= 1'b0;
            cnt        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            fifo_level <= level_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            busy <= pop || ((state != ST_IDLE) && !exit_now) || (level_next != '0);

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        cs   <= head[14:10];
                        addr <= head[9:8];
                        din  <= head[7:0];
                        if (head[14:10] != 5'd0) begin
                            state <= ST_SETUP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= wait_load;
                        end
                    end
                end
                ST_SETUP: begin
                    wr_n  <= 1'b0;
                    cnt   <= STROBE_LOAD;
                    state <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (cnt == '0) begin
                        wr_n  <= 1'b1;
                        state <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    cs    <= '0;
                    cnt   <= addr[0] ? DATA_LOAD : ADDR_LOAD;
                    state <= ST_GAP;
                end
                ST_GAP, ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ym_cmd_sequencer.sv
// Directed bench for ym_cmd_sequencer: timing of writes, gaps, waits, FIFO fill and reset.
module tb_ym_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [14:0] cmd_data;
    logic [4:0]  cs;
    logic [1:0]  addr;
    logic [7:0]  din;
    logic        wr_n;
    logic        busy;
    logic [4:0]  fifo_level;

    ym_cmd_sequencer #(
        .FIFO_DEPTH(16), .WR_PULSE(6), .ADDR_GAP(12), .DATA_GAP(192)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cs(cs), .addr(addr), .din(din), .wr_n(wr_n),
        .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;
    int k;

    int         fall_cyc[$];
    logic [4:0] fall_cs[$];
    logic [7:0] fall_din[$];
    logic       prev_wr = 1'b1;

    // log every falling edge of the write strobe with the bus contents
    always @(negedge clk) begin
        if (prev_wr === 1'b1 && wr_n === 1'b0) begin
            fall_cyc.push_back(cyc);
            fall_cs.push_back(cs);
            fall_din.push_back(din);
        end
        prev_wr = wr_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_falls();
        fall_cyc.delete();
        fall_cs.delete();
        fall_din.delete();
    endtask

    task automatic push(input logic [14:0] d);
        int t;
        cmd_data  = d;
        cmd_valid = 1'b1;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) chk("push_ready_timeout", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < budget) begin
            step(1);
            t++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_falls(input int n, input int budget);
        int t;
        t = 0;
        while (fall_cyc.size() < n && t < budget) begin
            step(1);
            t++;
        end
        step(1);
        chk("fall_count", fall_cyc.size(), n);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_data  = {5'd7, 2'd1, 8'hAB};
        step(3);
        chk("rst_cs", cs, 0);
        chk("rst_addr", addr, 0);
        chk("rst_din", din, 0);
        chk("rst_wr_n", wr_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", cmd_ready, 0);
        cmd_valid = 1'b0;
        rst       = 1'b0;
        step(1);
        chk("post_rst_level", fifo_level, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ready", cmd_ready, 1);

        // single data write
        clear_falls();
        push({5'd3, 2'd1, 8'h5A});
        k = cyc;
        chk("sw_level_k", fifo_level, 1);
        chk("sw_cs_k", cs, 0);
        chk("sw_busy_k", busy, 1);
        step(1);
        chk("sw_cs_k1", cs, 3);
        chk("sw_addr_k1", addr, 1);
        chk("sw_din_k1", din, 8'h5A);
        chk("sw_wr_k1", wr_n, 1);
        chk("sw_level_k1", fifo_level, 0);
        step(1);
        for (int i = 0; i < 6; i++) begin
            chk("sw_wr_low", wr_n, 0);
            chk("sw_cs_strobe", cs, 3);
            step(1);
        end
        chk("sw_wr_k8", wr_n, 1);
        chk("sw_cs_k8", cs, 3);
        step(1);
        chk("sw_cs_k9", cs, 0);
        chk("sw_addr_k9", addr, 1);
        chk("sw_din_k9", din, 8'h5A);
        chk("sw_busy_k9", busy, 1);
        step(191);
        chk("sw_busy_k200", busy, 1);
        step(1);
        chk("sw_busy_k201", busy, 0);
        chk("sw_falls", fall_cyc.size(), 1);
        chk("sw_fall_cyc", fall_cyc[0] - k, 2);

        // register-select then data write spacing
        clear_falls();
        push({5'd1, 2'd0, 8'h28});
        push({5'd1, 2'd1, 8'hF0});
        wait_falls(2, 200);
        chk("pair_spacing", fall_cyc[1] - fall_cyc[0], 21);
        chk("pair_din0", fall_din[0], 8'h28);
        chk("pair_din1", fall_din[1], 8'hF0);
        wait_idle(500);

        // fill the FIFO behind a 64-cycle wait
        clear_falls();
        push({5'd0, 2'd0, 8'h00});
        step(2);
        for (int i = 0; i < 16; i++) push({5'(i + 1), 2'd0, 8'(8'h10 + i)});
        chk("full_level", fifo_level, 16);
        chk("full_ready", cmd_ready, 0);
        chk("full_busy", busy, 1);
        push({5'd17, 2'd0, 8'h20});
        wait_falls(17, 2000);
        for (int i = 0; i < 17; i++) begin
            chk("full_order_cs", fall_cs[i], i + 1);
            chk("full_order_din", fall_din[i], 8'h10 + i);
        end
        wait_idle(500);

        // wait command, then a write
        clear_falls();
        push({5'd0, 2'd0, 8'h03});
        k = cyc;
        push({5'd2, 2'd1, 8'h77});
        begin
            int t;
            t = 0;
            while (cs !== 5'd2 && t < 1000) begin
                step(1);
                t++;
            end
        end
        chk("wait_cs", cs, 2);
        chk("wait_latency", cyc - k, 258);
        wait_idle(500);
        chk("wait_falls", fall_cyc.size(), 1);
        chk("wait_din", fall_din[0], 8'h77);

        // reset on the third low cycle of the strobe with four queued
        clear_falls();
        for (int i = 0; i < 5; i++) push({5'd4, 2'd1, 8'(i)});
        chk("rs_wr_low", wr_n, 0);
        chk("rs_level", fifo_level, 4);
        rst = 1'b1;
        step(1);
        chk("rs_wr_n", wr_n, 1);
        chk("rs_cs", cs, 0);
        chk("rs_level0", fifo_level, 0);
        chk("rs_busy", busy, 0);
        chk("rs_ready", cmd_ready, 0);
        rst = 1'b0;
        step(100);
        chk("rs_no_strobes", fall_cyc.size(), 1);
        chk("rs_busy_after", busy, 0);
        chk("rs_level_after", fifo_level, 0);

        // push and pop on the same edge at level 1
        clear_falls();
        push({5'd5, 2'd0, 8'h11});
        chk("pp_level_k", fifo_level, 1);
        push({5'd6, 2'd1, 8'h22});
        chk("pp_level_k1", fifo_level, 1);
        chk("pp_cs_k1", cs, 5);
        wait_falls(2, 200);
        chk("pp_cs_next", fall_cs[1], 6);
        chk("pp_din_next", fall_din[1], 8'h22);
        wait_idle(500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
